// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, size defaults and byte-lane indices for the SRAM emulator.
package sram_pkg;
  localparam int DEPTH_DEF = 4096;
  localparam int ADDR_W_DEF = 12;
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;
  typedef enum logic [2:0] {CLEAR, IDLE, READ, WRITE, COMMIT} state_t;
endpackage

// File: rtl/sram_byte_ram.sv
// sram_byte_ram: single-port DEPTH x 16 RAM with per-byte write enables and registered read.
module sram_byte_ram
  import sram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic [1:0]        we,
  output logic [15:0]       rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we[LANE_LO]) mem[addr][LANE_LO*8 +: 8] <= wdata[LANE_LO*8 +: 8];
    if (we[LANE_HI]) mem[addr][LANE_HI*8 +: 8] <= wdata[LANE_HI*8 +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sram_emulator.sv
// sram_emulator: async-SRAM style bus front end (clear sweep, read/write/commit FSM) over on-chip RAM.
module sram_emulator
  import sram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] A,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  inout  wire  [15:0] Data,
  output logic        Init_Done,
  output logic        Access_Err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt, cap_addr, ram_addr;
  logic [15:0] cap_data, rd, q;
  logic [1:0] ram_we;
  logic cap_ub, cap_lb, cap_oor, rd_oor, oor;
  assign oor = |A[19:ADDR_W];
  always_comb begin
    nxt = state;
    case (state)
      CLEAR:   nxt = (cnt == LAST) ? IDLE : CLEAR;
      IDLE:    nxt = (!CE && !WE) ? WRITE : (!CE && !OE) ? READ : IDLE;
      READ:    nxt = CE ? IDLE : !WE ? WRITE : OE ? IDLE : READ;
      WRITE:   nxt = (WE || CE) ? COMMIT : WRITE;
      default: nxt = IDLE;
    endcase
  end
  // The single RAM port is shared: sweep counter, committed write, or live bus address.
  assign ram_addr = (state == CLEAR) ? cnt : (state == COMMIT) ? cap_addr : A[ADDR_W-1:0];
  assign ram_we = (state == CLEAR) ? 2'b11 :
                  (state == COMMIT && !cap_oor) ? {~cap_ub, ~cap_lb} : 2'b00;
  sram_byte_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(Clk), .addr(ram_addr), .wdata((state == CLEAR) ? 16'h0000 : cap_data),
    .we(ram_we), .rdata(rd)
  );
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
      cnt <= '0;
      Init_Done <= 1'b0;
      Access_Err <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_ub <= 1'b1;
      cap_lb <= 1'b1;
      cap_oor <= 1'b0;
      rd_oor <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt + ADDR_W'(state == CLEAR);
      Init_Done <= nxt != CLEAR;
      Access_Err <= oor && ((nxt == READ && state != READ) || (nxt == WRITE && state != WRITE));
      rd_oor <= oor;
      if (nxt == WRITE) begin
        cap_addr <= A[ADDR_W-1:0];
        cap_data <= Data;
        cap_ub <= UB;
        cap_lb <= LB;
        cap_oor <= oor;
      end
    end
  end
  assign q = rd_oor ? 16'h0000 : rd;
  assign Data[LANE_HI*8 +: 8] = (state == READ && !UB) ? q[LANE_HI*8 +: 8] : 8'hzz;
  assign Data[LANE_LO*8 +: 8] = (state == READ && !LB) ? q[LANE_LO*8 +: 8] : 8'hzz;
endmodule

// File: tb/tb_sram_emulator.sv
// tb_sram_emulator: table-driven and randomized checks of sram_emulator against an array model.
module tb_sram_emulator;
  logic Clk = 0, Reset = 0, CE = 1, OE = 1, WE = 1, UB = 1, LB = 1, drv_en = 0;
  logic [19:0] A = '0;
  logic [15:0] drv = '0;
  logic Init_Done, Access_Err;
  wire [15:0] Data;
  int checks = 0, errors = 0;
  logic [15:0] mem [4096];

  typedef struct {
    logic [19:0] a;
    logic [15:0] d;
    logic ub, lb;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [7];

  assign Data = drv_en ? drv : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (Data[g]);
  end
  always #5 Clk = ~Clk;

  sram_emulator dut (
    .Clk(Clk), .Reset(Reset), .A(A), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .Data(Data), .Init_Done(Init_Done), .Access_Err(Access_Err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle;
    CE = 1; OE = 1; WE = 1; UB = 1; LB = 1; drv_en = 0;
  endtask

  function automatic logic [15:0] expect_rd(input logic [19:0] a, input logic ub, input logic lb);
    logic [15:0] v;
    v = (a < 20'd4096) ? mem[a[11:0]] : 16'h0000;
    return {ub ? 8'hFF : v[15:8], lb ? 8'hFF : v[7:0]};
  endfunction

  task automatic model_wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    if (a < 20'd4096) begin
      if (!lb) mem[a[11:0]][7:0] = d[7:0];
      if (!ub) mem[a[11:0]][15:8] = d[15:8];
    end
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    A = a; drv = d; drv_en = 1; UB = ub; LB = lb; CE = 0; WE = 0; OE = 1;
    tick;
    chk("wr_err", 16'(Access_Err), 16'(a >= 20'd4096));
    bus_idle;
    tick;
    chk("wr_err_pulse", 16'(Access_Err), 16'd0);
    tick;
    model_wr(a, d, ub, lb);
  endtask

  task automatic rd(input logic [19:0] a, input logic ub, input logic lb, input logic [15:0] exp);
    A = a; UB = ub; LB = lb; CE = 0; OE = 0; WE = 1; drv_en = 0;
    tick;
    chk("rd_data", Data, exp);
    chk("rd_err", 16'(Access_Err), 16'(a >= 20'd4096));
    CE = 1; OE = 1;
    tick;
    chk("rd_hiz", Data, 16'hFFFF);
    chk("rd_err_pulse", 16'(Access_Err), 16'd0);
    bus_idle;
  endtask

  task automatic sweep;
    int n;
    n = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    while (!Init_Done && n < 5000) begin
      @(posedge Clk);
      n++;
      #1;
    end
    chk("init_cycles", 16'(n), 16'd4096);
  endtask

  initial begin
    tbl[0] = '{20'h00010, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
    tbl[1] = '{20'h00020, 16'h1234, 1'b1, 1'b0, 16'h0034};
    tbl[2] = '{20'h00030, 16'h5678, 1'b0, 1'b1, 16'h5600};
    tbl[3] = '{20'h00040, 16'h9999, 1'b1, 1'b1, 16'h0000};
    tbl[4] = '{20'h01000, 16'hABCD, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{20'h00FFF, 16'hFFF0, 1'b0, 1'b0, 16'hFFF0};
    tbl[6] = '{20'h80000, 16'h1111, 1'b0, 1'b0, 16'h0000};
    #2 Reset = 1;
    #1;
    chk("rst_init_done", 16'(Init_Done), 16'd0);
    chk("rst_err", 16'(Access_Err), 16'd0);
    chk("rst_hiz", Data, 16'hFFFF);
    tick;
    #2 Reset = 0;
    sweep;
    rd(20'h00123, 0, 0, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].a, tbl[i].d, tbl[i].ub, tbl[i].lb);
      rd(tbl[i].a, 0, 0, tbl[i].exp);
    end
    rd(20'h00000, 0, 0, 16'h0000);
    // read stays open while the address moves
    A = 20'h00010; UB = 0; LB = 0; CE = 0; OE = 0; WE = 1;
    tick;
    chk("stream0", Data, 16'hBEEF);
    A = 20'h00020;
    tick;
    chk("stream1", Data, 16'h0034);
    UB = 1;
    #1 chk("lane_off", Data, 16'hFF34);
    CE = 1;
    tick;
    chk("stream_hiz", Data, 16'hFFFF);
    bus_idle;
    // OE and WE low together: write wins and the bus is left alone
    A = 20'h00050; drv = 16'h7777; drv_en = 1; UB = 0; LB = 0; CE = 0; OE = 0; WE = 0;
    tick;
    drv_en = 0; CE = 1; OE = 1; WE = 1;
    #1 chk("both_nodrive", Data, 16'hFFFF);
    tick;
    tick;
    model_wr(20'h00050, 16'h7777, 0, 0);
    rd(20'h00050, 0, 0, 16'h7777);
    for (int i = 0; i < 300; i++) begin
      logic [19:0] a;
      logic [15:0] d;
      logic ub, lb;
      a = ($urandom_range(0, 9) == 0) ? 20'h01000 | 20'($urandom_range(0, 20'hFEFFF)) : 20'($urandom_range(0, 63));
      d = 16'($urandom);
      ub = 1'($urandom);
      lb = 1'($urandom);
      if ($urandom_range(0, 1) == 0) wr(a, d, ub, lb);
      else rd(a, ub, lb, expect_rd(a, ub, lb));
    end
    // reset lands in the middle of a write
    wr(20'h00005, 16'h1111, 0, 0);
    rd(20'h00005, 0, 0, 16'h1111);
    A = 20'h00005; drv = 16'hAAAA; drv_en = 1; UB = 0; LB = 0; CE = 0; WE = 0;
    tick;
    #2 Reset = 1;
    bus_idle;
    #1;
    chk("mid_rst_hiz", Data, 16'hFFFF);
    chk("mid_rst_done", 16'(Init_Done), 16'd0);
    chk("mid_rst_err", 16'(Access_Err), 16'd0);
    tick;
    #2 Reset = 0;
    sweep;
    rd(20'h00005, 0, 0, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_emulator.md
SRAM_EMULATOR -- requirements
Module: sram_emulator

Interface
REQ-001 Parameter DEPTH, default 4096: number of 16-bit words implemented on chip.
REQ-002 Parameter ADDR_W, default 12: internal address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 A  input  20  word address from the processor.
REQ-006 CE, OE, WE, UB, LB  input  1 each  active-low chip, output, write, upper-byte and lower-byte enables.
REQ-007 Data  inout  16  shared bidirectional data bus; bits [15:8] are the upper lane and bits [7:0] the lower lane.
REQ-008 Init_Done  output  1  high once the power-up clear sweep completes.
REQ-009 Access_Err  output  1  single-cycle pulse on an access to an address at or above DEPTH.

Function
REQ-010 The state machine SHALL have the states CLEAR, IDLE, READ, WRITE and COMMIT.
REQ-011 CLEAR: one word is written to 16'h0000 per cycle, addresses 0..DEPTH-1; after the last word the state becomes IDLE and Init_Done rises.
REQ-012 While in CLEAR, all bus activity is ignored, Data is Hi-Z and Access_Err stays 0.
REQ-013 IDLE -> WRITE when CE=0 and WE=0 are sampled; WE=0 has priority over OE.
REQ-014 IDLE -> READ when CE=0, OE=0 and WE=1 are sampled.
REQ-015 READ: Data is driven starting 1 cycle after the read is sampled (read latency 1).
REQ-016 READ: each lane is driven only while its enable (UB or LB) is 0; a disabled lane is Hi-Z.
REQ-017 READ: each cycle reflects the currently sampled A; an address change while in READ returns the new word 1 cycle later.
REQ-018 READ -> IDLE when CE=1 or OE=1 is sampled; Data goes Hi-Z on that same edge.
REQ-019 READ -> WRITE when WE=0 is sampled; Data goes Hi-Z on that edge.
REQ-020 WRITE: each cycle captures A, Data, UB and LB; Data is never driven in WRITE.
REQ-021 WRITE -> COMMIT when WE=1 or CE=1 is sampled; the last values captured while WE was low are used.
REQ-022 COMMIT: the captured lanes whose enable was 0 are written in a single cycle; lanes with enable 1 keep their old contents; the next state is IDLE.
REQ-023 If both UB and LB are 1 during a write, COMMIT writes nothing.
REQ-024 Address bits A[19:ADDR_W] nonzero: reads drive 16'h0000 on the enabled lanes, writes are dropped, and Access_Err pulses for 1 cycle when READ or WRITE is entered.
REQ-025 A write-then-read to the same address SHALL return the new data; a read entered 1 cycle after COMMIT sees the committed value.
REQ-026 Data SHALL never be driven in any state other than READ.

Reset
REQ-027 Reset asserted: state becomes CLEAR, the clear counter becomes 0, Init_Done is 0, Access_Err is 0 and Data is Hi-Z, immediately and without a clock.
REQ-028 A pending WRITE or COMMIT interrupted by Reset SHALL be discarded.
REQ-029 Memory contents are not touched by reset itself; they are zeroed only by the CLEAR sweep that follows.
REQ-030 Deassertion of Reset SHALL begin the sweep on the next Clk edge, so Init_Done rises DEPTH cycles later.

Structure
REQ-031 Package sram_pkg SHALL hold the state enum, the DEPTH and ADDR_W defaults, and the lane-index constants.
REQ-032 Sub-module sram_byte_ram SHALL hold the storage: a single-port RAM of DEPTH x 16 with two byte-write enables and a registered read.
REQ-033 The top level SHALL hold the FSM, capture registers, range check and tri-state drivers.

Verification
REQ-034 Reset pulse, then wait for the sweep -> Init_Done rises exactly 4096 cycles after release; a read of address 0x00123 returns 16'h0000.
REQ-035 Write 16'hBEEF to 0x00010 with UB=LB=0, then read -> Data = 16'hBEEF 1 cycle after the read is sampled; Hi-Z 1 cycle after OE=1.
REQ-036 Write 16'h1234 to 0x00020 with UB=1, LB=0, then read with both lanes enabled -> 16'h0034.
REQ-037 Read or write at 0x01000 -> one Access_Err pulse; the read returns 16'h0000; address 0x00000 is unchanged.
REQ-038 Reset asserted mid-WRITE of 16'hAAAA to 0x00005 -> bus Hi-Z immediately; after the sweep, address 0x00005 reads 16'h0000.
REQ-039 CE=0 with OE=0 and WE=0 together -> no bus drive, WRITE is entered and the data is committed.
